// File: rtl/reflet_vga_term_pkg.sv
// Shared constants and types for the terminal-style text-mode VGA write controller.
package reflet_vga_term_pkg;

    localparam int unsigned FONT_WIDTH  = 8;
    localparam int unsigned FONT_HEIGHT = 8;

    localparam logic [7:0] CC_BS    = 8'h08;
    localparam logic [7:0] CC_LF    = 8'h0A;
    localparam logic [7:0] CC_FF    = 8'h0C;
    localparam logic [7:0] CC_CR    = 8'h0D;
    localparam logic [7:0] CC_SPACE = 8'h20;
    localparam logic [7:0] CC_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CUR_NOP  = 3'd0,
        CUR_INC  = 3'd1,
        CUR_LF   = 3'd2,
        CUR_CR   = 3'd3,
        CUR_DEC  = 3'd4,
        CUR_HOME = 3'd5
    } cur_op_t;

    // Everything from space upward except DEL produces a glyph write.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CC_SPACE) && (c != CC_DEL);
    endfunction

endpackage

// File: rtl/reflet_vga_term_if.sv
// Byte-stream input and text-cell write port of the terminal controller.
interface reflet_vga_term_if
    import reflet_vga_term_pkg::*;
#(
    parameter int unsigned H_SIZE        = 640,
    parameter int unsigned V_SIZE        = 480,
    parameter int unsigned COLOR_DEPTH   = 8,
    parameter int unsigned BIT_REDUCTION = 0
);
    localparam int unsigned CW = $clog2(H_SIZE / FONT_WIDTH) - BIT_REDUCTION;
    localparam int unsigned RW = $clog2(V_SIZE / FONT_HEIGHT) - BIT_REDUCTION;
    localparam int unsigned CD = COLOR_DEPTH;

    logic          char_valid;
    logic          char_ready;
    logic [7:0]    char_in;
    logic [CD-1:0] fg_r_in, fg_g_in, fg_b_in;
    logic [CD-1:0] bg_r_in, bg_g_in, bg_b_in;
    logic          clear_req;
    logic          busy;

    logic          write_en;
    logic [CW-1:0] h_txt_out;
    logic [RW-1:0] v_txt_out;
    logic [7:0]    char_out;
    logic [CD-1:0] fg_r_out, fg_g_out, fg_b_out;
    logic [CD-1:0] bg_r_out, bg_g_out, bg_b_out;
    logic [CW-1:0] cursor_h;
    logic [RW-1:0] cursor_v;

    modport slave (
        input  char_valid, char_in, fg_r_in, fg_g_in, fg_b_in,
               bg_r_in, bg_g_in, bg_b_in, clear_req,
        output char_ready, busy, write_en, h_txt_out, v_txt_out, char_out,
               fg_r_out, fg_g_out, fg_b_out, bg_r_out, bg_g_out, bg_b_out,
               cursor_h, cursor_v
    );

    modport master (
        output char_valid, char_in, fg_r_in, fg_g_in, fg_b_in,
               bg_r_in, bg_g_in, bg_b_in, clear_req,
        input  char_ready, busy, write_en, h_txt_out, v_txt_out, char_out,
               fg_r_out, fg_g_out, fg_b_out, bg_r_out, bg_g_out, bg_b_out,
               cursor_h, cursor_v
    );

endinterface

// File: rtl/reflet_vga_term_cursor.sv
// Column/row cursor with increment, newline, CR, backspace and home; wraps at COLS/ROWS.
module reflet_vga_term_cursor
    import reflet_vga_term_pkg::*;
#(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 60,
    parameter int unsigned CW   = 7,
    parameter int unsigned RW   = 6
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  cur_op_t       i_op,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last_c
);

    logic [CW-1:0] r_col, w_col_next;
    logic [RW-1:0] r_row, w_row_next, w_row_inc;
    logic          w_col_end;
    logic          w_row_end;

    assign w_col_end = (r_col == CW'(COLS - 1));
    assign w_row_end = (r_row == RW'(ROWS - 1));
    // Bottom row wraps to the top; there is no scrolling.
    assign w_row_inc = w_row_end ? '0 : r_row + RW'(1);

    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        case (i_op)
            CUR_INC: begin
                if (w_col_end) begin
                    w_col_next = '0;
                    w_row_next = w_row_inc;
                end else begin
                    w_col_next = r_col + CW'(1);
                end
            end
            CUR_LF: begin
                w_col_next = '0;
                w_row_next = w_row_inc;
            end
            CUR_CR:  w_col_next = '0;
            CUR_DEC: begin
                if (r_col != '0) w_col_next = r_col - CW'(1);
            end
            CUR_HOME: begin
                w_col_next = '0;
                w_row_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    assign o_col    = r_col;
    assign o_row    = r_row;
    assign o_last_c = w_col_end && w_row_end;

endmodule

// File: rtl/reflet_vga_term.sv
// Terminal write controller: byte stream in, single-cycle text-cell writes out, with full-screen clear.
module reflet_vga_term
    import reflet_vga_term_pkg::*;
#(
    parameter int unsigned H_SIZE        = 640,
    parameter int unsigned V_SIZE        = 480,
    parameter int unsigned COLOR_DEPTH   = 8,
    parameter int unsigned BIT_REDUCTION = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    reflet_vga_term_if.slave bus
);

    localparam int unsigned COLS  = H_SIZE / FONT_WIDTH / (2 ** BIT_REDUCTION);
    localparam int unsigned ROWS  = V_SIZE / FONT_HEIGHT / (2 ** BIT_REDUCTION);
    localparam int unsigned CW    = $clog2(H_SIZE / FONT_WIDTH) - BIT_REDUCTION;
    localparam int unsigned RW    = $clog2(V_SIZE / FONT_HEIGHT) - BIT_REDUCTION;
    localparam int unsigned CD    = COLOR_DEPTH;
    localparam int unsigned CLR_W = 3 * CD;

    state_t          r_state, w_state_next;
    cur_op_t         w_cur_op;
    logic [CW-1:0]   w_cur_h;
    logic [RW-1:0]   w_cur_v;
    logic            w_cur_last;

    logic            r_write_en, w_write_en;
    logic [CW-1:0]   r_h_txt, w_h_txt;
    logic [RW-1:0]   r_v_txt, w_v_txt;
    logic [7:0]      r_char_out, w_char_out;
    logic [CLR_W-1:0] r_fg, w_fg, r_bg, w_bg, r_clr, w_clr;
    logic            r_busy;
    logic [CLR_W-1:0] w_fg_in, w_bg_in;
    logic            w_ready;

    assign w_fg_in = {bus.fg_r_in, bus.fg_g_in, bus.fg_b_in};
    assign w_bg_in = {bus.bg_r_in, bus.bg_g_in, bus.bg_b_in};
    // A same-cycle clear request wins over the byte, so ready drops immediately.
    assign w_ready = (r_state == ST_IDLE) && !bus.clear_req;

    // The clear scan walks the screen with the cursor itself and ends back at home.
    reflet_vga_term_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_cursor (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_op     (w_cur_op),
        .o_col    (w_cur_h),
        .o_row    (w_cur_v),
        .o_last_c (w_cur_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_cur_op     = CUR_NOP;
        w_write_en   = 1'b0;
        w_h_txt      = r_h_txt;
        w_v_txt      = r_v_txt;
        w_char_out   = r_char_out;
        w_fg         = r_fg;
        w_bg         = r_bg;
        w_clr        = r_clr;
        case (r_state)
            ST_CLEAR: begin
                w_write_en = 1'b1;
                w_h_txt    = w_cur_h;
                w_v_txt    = w_cur_v;
                w_char_out = CC_SPACE;
                w_fg       = r_clr;
                w_bg       = r_clr;
                w_cur_op   = CUR_INC;
                if (w_cur_last) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.clear_req) begin
                    w_clr        = w_bg_in;
                    w_cur_op     = CUR_HOME;
                    w_state_next = ST_CLEAR;
                end else if (bus.char_valid) begin
                    w_state_next = ST_EXEC;
                    if (is_printable(bus.char_in)) begin
                        w_write_en = 1'b1;
                        w_h_txt    = w_cur_h;
                        w_v_txt    = w_cur_v;
                        w_char_out = bus.char_in;
                        w_fg       = w_fg_in;
                        w_bg       = w_bg_in;
                        w_cur_op   = CUR_INC;
                    end else begin
                        case (bus.char_in)
                            CC_LF: w_cur_op = CUR_LF;
                            CC_CR: w_cur_op = CUR_CR;
                            CC_BS: w_cur_op = CUR_DEC;
                            CC_FF: begin
                                w_clr        = w_bg_in;
                                w_cur_op     = CUR_HOME;
                                w_state_next = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_EXEC: w_state_next = ST_IDLE;
            default: w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_CLEAR;
            r_write_en <= 1'b0;
            r_h_txt    <= '0;
            r_v_txt    <= '0;
            r_char_out <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_clr      <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_write_en <= w_write_en;
            r_h_txt    <= w_h_txt;
            r_v_txt    <= w_v_txt;
            r_char_out <= w_char_out;
            r_fg       <= w_fg;
            r_bg       <= w_bg;
            r_clr      <= w_clr;
            r_busy     <= (w_state_next == ST_CLEAR);
        end
    end

    assign bus.char_ready = w_ready;
    assign bus.busy       = r_busy;
    assign bus.write_en   = r_write_en;
    assign bus.h_txt_out  = r_h_txt;
    assign bus.v_txt_out  = r_v_txt;
    assign bus.char_out   = r_char_out;
    assign bus.fg_r_out   = r_fg[2*CD +: CD];
    assign bus.fg_g_out   = r_fg[CD   +: CD];
    assign bus.fg_b_out   = r_fg[0    +: CD];
    assign bus.bg_r_out   = r_bg[2*CD +: CD];
    assign bus.bg_g_out   = r_bg[CD   +: CD];
    assign bus.bg_b_out   = r_bg[0    +: CD];
    assign bus.cursor_h   = w_cur_h;
    assign bus.cursor_v   = w_cur_v;

endmodule

// File: tb/tb_reflet_vga_term.sv
// Scoreboard bench for reflet_vga_term: expected cell writes are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_reflet_vga_term;

    localparam int unsigned COLS  = 80;
    localparam int unsigned ROWS  = 60;
    localparam int unsigned CELLS = COLS * ROWS;

    typedef struct packed {
        logic [6:0]  h;
        logic [5:0]  v;
        logic [7:0]  c;
        logic [23:0] fg;
        logic [23:0] bg;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reflet_vga_term_if bus ();

    reflet_vga_term dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  exp_h    = 0;
    int  exp_v    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_col(input logic [23:0] fg, input logic [23:0] bg);
        bus.fg_r_in = fg[23:16]; bus.fg_g_in = fg[15:8]; bus.fg_b_in = fg[7:0];
        bus.bg_r_in = bg[23:16]; bus.bg_g_in = bg[15:8]; bus.bg_b_in = bg[7:0];
    endtask

    task automatic push_clear(input logic [23:0] col);
        for (int v = 0; v < int'(ROWS); v++)
            for (int h = 0; h < int'(COLS); h++)
                exp_q.push_back({7'(h), 6'(v), 8'h20, col, col});
    endtask

    // Monitor: every strobed write must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        wr_t act;
        wr_t exp;
        if (bus.write_en === 1'b1) begin
            act = {bus.h_txt_out, bus.v_txt_out, bus.char_out,
                   bus.fg_r_out, bus.fg_g_out, bus.fg_b_out,
                   bus.bg_r_out, bus.bg_g_out, bus.bg_b_out};
            n_checks++;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got (%0d,%0d) char 0x%0h, expected no write",
                         act.h, act.v, act.c);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cell_write: got (%0d,%0d) c=%0h fg=%0h bg=%0h expected (%0d,%0d) c=%0h fg=%0h bg=%0h",
                             act.h, act.v, act.c, act.fg, act.bg, exp.h, exp.v, exp.c, exp.fg, exp.bg);
                end
            end
        end
    end

    task automatic adv_row();
        exp_v = (exp_v == int'(ROWS) - 1) ? 0 : exp_v + 1;
    endtask

    task automatic send_byte(input logic [7:0] c, input logic [23:0] fg, input logic [23:0] bg);
        logic pr;
        pr = (c >= 8'h20) && (c != 8'h7F);
        bus.char_valid = 1'b1;
        bus.char_in    = c;
        set_col(fg, bg);
        chk("ready_before_byte", 32'(bus.char_ready), 32'd1);
        if (pr) begin
            exp_q.push_back({7'(exp_h), 6'(exp_v), c, fg, bg});
            if (exp_h == int'(COLS) - 1) begin exp_h = 0; adv_row(); end
            else exp_h++;
        end else begin
            case (c)
                8'h0A: begin exp_h = 0; adv_row(); end
                8'h0D: exp_h = 0;
                8'h08: if (exp_h > 0) exp_h--;
                default: ;
            endcase
        end
        tick();
        bus.char_valid = 1'b0;
        chk("write_en_after_byte", 32'(bus.write_en), 32'(pr));
        chk("cursor_h_after_byte", 32'(bus.cursor_h), 32'(exp_h));
        chk("cursor_v_after_byte", 32'(bus.cursor_v), 32'(exp_v));
        tick();
    endtask

    task automatic chk_cursor(input string name, input int h, input int v);
        chk({name, "_h"}, 32'(bus.cursor_h), 32'(h));
        chk({name, "_v"}, 32'(bus.cursor_v), 32'(v));
    endtask

    // Runs out a clear in progress; optionally pulses clear_req at cycle pulse_at.
    task automatic wait_clear_done(input string name, input int w0, input int pulse_at);
        int cyc;
        cyc = 0;
        while (bus.busy !== 1'b0 && cyc < int'(CELLS) + 100) begin
            chk({name, "_ready_while_busy"}, 32'(bus.char_ready), 32'd0);
            bus.clear_req = (cyc == pulse_at);
            tick();
            cyc++;
        end
        bus.clear_req  = 1'b0;
        bus.char_valid = 1'b0;
        if (bus.busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, cyc);
        end
        tick();
        chk({name, "_write_en_after"}, 32'(bus.write_en), 32'd0);
        chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({name, "_ready_after"}, 32'(bus.char_ready), 32'd1);
        chk_cursor({name, "_cursor"}, 0, 0);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_write_count"}, 32'(n_writes - w0), 32'(CELLS));
        exp_h = 0;
        exp_v = 0;
    endtask

    initial begin : stim
        int w0;
        int cyc;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        bus.clear_req  = 1'b0;
        set_col(24'h0, 24'h0);
        push_clear(24'h000000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        chk("rst_ready", 32'(bus.char_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_h_txt", 32'(bus.h_txt_out), 32'd0);
        chk("rst_v_txt", 32'(bus.v_txt_out), 32'd0);
        chk("rst_char_out", 32'(bus.char_out), 32'd0);
        chk("rst_bg_b_out", 32'(bus.bg_b_out), 32'd0);
        chk_cursor("rst_cursor", 0, 0);

        rst = 1'b0;
        w0  = n_writes;
        tick();
        chk("first_clear_write_en", 32'(bus.write_en), 32'd1);
        chk("first_clear_h", 32'(bus.h_txt_out), 32'd0);
        chk("first_clear_v", 32'(bus.v_txt_out), 32'd0);
        wait_clear_done("init_clear", w0, -1);

        send_byte(8'h41, 24'hFF0000, 24'h0000FF);
        chk_cursor("after_A", 1, 0);
        repeat (5) send_byte(8'h0A, 24'h0, 24'h0);
        repeat (79) send_byte(8'h61, 24'h00FF00, 24'h101010);
        chk_cursor("at_79_5", 79, 5);
        send_byte(8'h5A, 24'hABCDEF, 24'h012345);
        chk_cursor("after_Z", 0, 6);
        repeat (53) send_byte(8'h0A, 24'h0, 24'h0);
        repeat (10) send_byte(8'h62, 24'h202020, 24'h303030);
        chk_cursor("at_10_59", 10, 59);
        send_byte(8'h0A, 24'h0, 24'h0);
        chk_cursor("lf_wrap", 0, 0);
        repeat (3) send_byte(8'h0A, 24'h0, 24'h0);
        send_byte(8'h08, 24'h0, 24'h0);
        chk_cursor("bs_at_col0", 0, 3);
        send_byte(8'h07, 24'h0, 24'h0);
        chk_cursor("bell_ignored", 0, 3);
        send_byte(8'h7F, 24'h0, 24'h0);
        send_byte(8'h80, 24'h111111, 24'h222222);
        repeat (41) send_byte(8'h63, 24'h333333, 24'h444444);
        chk_cursor("at_42_3", 42, 3);
        send_byte(8'h08, 24'h0, 24'h0);
        chk_cursor("bs_mid", 41, 3);
        send_byte(8'h64, 24'h555555, 24'h666666);
        send_byte(8'h0D, 24'h0, 24'h0);
        chk_cursor("cr", 0, 3);

        // Form feed clear with a byte held valid and a stray clear_req.
        push_clear(24'h123456);
        w0 = n_writes;
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h0C;
        set_col(24'h777777, 24'h123456);
        chk("ready_before_ff", 32'(bus.char_ready), 32'd1);
        tick();
        bus.char_in = 8'h58;
        set_col(24'h777777, 24'h654321);
        chk("ff_busy", 32'(bus.busy), 32'd1);
        wait_clear_done("ff_clear", w0, 1000);

        // clear_req beats a simultaneous byte; then reset mid-clear.
        push_clear(24'hAABBCC);
        w0 = n_writes;
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h51;
        bus.clear_req  = 1'b1;
        set_col(24'h0, 24'hAABBCC);
        #1;
        chk("ready_masked_by_clear_req", 32'(bus.char_ready), 32'd0);
        tick();
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;
        chk("clear_req_busy", 32'(bus.busy), 32'd1);
        cyc = 0;
        while (n_writes - w0 < 2000 && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("reached_cell_2000", 32'(n_writes - w0 >= 2000), 32'd1);
        rst = 1'b1;
        #1;
        chk("midclear_rst_write_en", 32'(bus.write_en), 32'd0);
        chk("midclear_rst_busy", 32'(bus.busy), 32'd1);
        chk("midclear_rst_ready", 32'(bus.char_ready), 32'd0);
        chk("midclear_rst_h_txt", 32'(bus.h_txt_out), 32'd0);
        chk_cursor("midclear_rst_cursor", 0, 0);
        exp_q.delete();
        push_clear(24'h000000);
        tick();
        rst = 1'b0;
        w0  = n_writes;
        tick();
        chk("restart_write_en", 32'(bus.write_en), 32'd1);
        chk("restart_h", 32'(bus.h_txt_out), 32'd0);
        chk("restart_v", 32'(bus.v_txt_out), 32'd0);
        wait_clear_done("post_reset_clear", w0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reflet_vga_term.md
Name: reflet_VGA_term

Overview:
- Terminal-style write controller for the text-mode VGA block.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor.
- Interprets a small set of control codes and sequences single-cycle writes into the text-cell memory write port: column, row, character, fg/bg RGB, write enable.
- Also runs a full-screen clear after reset and on request, so CPU-side logic never computes cell addresses.

Parameters:
- h_size, 640, horizontal resolution in pixels.
- v_size, 480, vertical resolution in pixels.
- color_depth, 8, bits per colour channel.
- bit_reduction, 0, log2 pixel-doubling factor; must match the text block.
- Derived constants: COLS = h_size/8/2^bit_reduction; ROWS = v_size/8/2^bit_reduction; CW = $clog2(h_size/8)-bit_reduction; RW = $clog2(v_size/8)-bit_reduction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- char_valid  in  1  byte available.
- char_ready  out  1  controller can accept a byte this cycle.
- char_in  in  8  byte (printable character or control code).
- R_fg_in, G_fg_in, B_fg_in  in  color_depth each  foreground colour; sampled with the byte.
- R_bg_in, G_bg_in, B_bg_in  in  color_depth each  background colour; sampled with the byte.
- clear_req  in  1  pulse: start full-screen clear using the current bg_in colour.
- busy  out  1  clear sequence in progress.
- write_en  out  1  text-memory write strobe.
- h_txt_out  out  CW  write column.
- v_txt_out  out  RW  write row.
- char_out  out  8  character to write.
- R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out  out  color_depth each  cell colours.
- cursor_h  out  CW  current cursor column.
- cursor_v  out  RW  current cursor row.

Behaviour:
- All outputs registered.
- Reset values: write_en=0, char_ready=0, busy=1, h/v_txt_out=0, char_out=0, all colour outputs 0, cursor=(0,0), clear colour register=0, state=CLEAR.
- States: CLEAR, IDLE, EXEC.
- CLEAR:
  - One write per cycle, column fastest: (0,0),(1,0)…(COLS-1,0),(0,1)…(COLS-1,ROWS-1).
  - Each write uses char_out=0x20 and fg=bg=clear colour.
  - First write_en occurs on the first clk edge after reset deasserts; exactly COLS*ROWS write cycles (4800 at defaults).
  - Then cursor=(0,0), busy=0, state=IDLE, char_ready=1 on the following cycle.
- IDLE:
  - char_ready=1.
  - Handshake completes when char_valid && char_ready: latch byte and colours, go to EXEC, char_ready=0.
  - clear_req in IDLE: latch bg_in as clear colour, go to CLEAR.
  - If clear_req and a handshake occur in the same cycle, clear_req wins and the byte is not accepted (char_ready drops in the same cycle combinationally from clear_req: char_ready = idle && !clear_req).
- EXEC: one cycle, then IDLE. Throughput is one byte per 2 cycles. Byte handling:
  - 0x20..0x7E and 0x80..0xFF (printable): write_en=1 at the current cursor with the latched byte and colours, then advance the cursor. The write is visible on outputs the cycle after the handshake.
  - 0x0A LF: cursor column=0, row+1. No write.
  - 0x0D CR: cursor column=0. No write.
  - 0x08 BS: column-1 if column>0, else no change; no row wrap-back. No write.
  - 0x0C FF: latch bg colour as clear colour, enter CLEAR (home cursor at the end).
  - Other 0x00..0x1F and 0x7F: ignored, no write, no cursor change.
- Cursor advance:
  - column==COLS-1 → column=0, row+1.
  - row+1 from ROWS-1 → row=0 (wrap to top, no scroll).
  - Wrap is compared against COLS/ROWS, not the power-of-two width.
- clear_req and char_valid are ignored while busy.
- write_en is low in IDLE and for non-printable EXEC.
- Reset asserted at any time, including mid-clear or mid-EXEC: immediately returns all state to reset values; a fresh full clear runs after release.

Decomposition:
- Shared package reflet_VGA_pkg:
  - FONT_WIDTH=8, FONT_HEIGHT=8.
  - Control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D, CC_SPACE=8'h20.
  - State encoding for CLEAR/IDLE/EXEC.
- One sub-module, reflet_VGA_term_cursor: column/row counter with increment, newline, carriage-return, decrement and home operations, and COLS/ROWS wrap. Instantiated once for the cursor; the clear scan reuses its increment logic.

Test Plan:
- Reset release with default params → exactly 4800 consecutive write_en cycles, first (0,0), last (79,59), char_out=0x20, colours 0; then busy=0, char_ready=1, cursor=(0,0).
- After clear, send 'A'(0x41) with fg=FF/00/00, bg=00/00/FF → next cycle write_en=1 at (0,0), char_out=0x41, R_fg_out=FF, B_bg_out=FF; cursor=(1,0).
- Cursor at (79,5), send 'Z' → write at (79,5), cursor=(0,6). Cursor at (10,59), send LF → cursor=(0,0), no write_en.
- Cursor at (0,3), send BS → cursor stays (0,3). Send 0x07 → no write, no cursor change. Send CR at (42,3) → cursor=(0,3).
- Send FF with bg=12/34/56 → 4800 writes with fg=bg=12/34/56; char_valid held high during busy is not accepted (char_ready=0 throughout); a clear_req pulse during the clear has no effect.
- Assert reset at clear cell 2000 → write_en=0 immediately; after release, the clear restarts at (0,0) with colour 0 and runs the full 4800 cycles.
